// File: rtl/riot_pia_pkg.sv
// Shared definitions for the 6532 RIOT PIA window: register offsets,
// prescale codes, timer mode encoding and small helper functions.
package riot_pia_pkg;

   // Window decode constants for the top-level address decoder (0280h-029Fh).
   localparam logic [12:0] PIA_BASE = 13'h0280;
   localparam logic [12:0] PIA_MASK = 13'h1FE0;

   // Register offsets within the window (address_bus[4:0]).
   localparam logic [4:0] OFS_SWCHA  = 5'h00;
   localparam logic [4:0] OFS_SWACNT = 5'h01;
   localparam logic [4:0] OFS_SWCHB  = 5'h02;
   localparam logic [4:0] OFS_SWBCNT = 5'h03;
   localparam logic [4:0] OFS_INTIM  = 5'h04;
   localparam logic [4:0] OFS_TIMINT = 5'h05;
   localparam logic [4:0] OFS_TIM1T  = 5'h14;
   localparam logic [4:0] OFS_TIM8T  = 5'h15;
   localparam logic [4:0] OFS_TIM64T = 5'h16;
   localparam logic [4:0] OFS_T1024T = 5'h17;

   // Prescale select codes (address bits A1:A0 of a timer load).
   localparam logic [1:0] PRE_1T    = 2'd0;
   localparam logic [1:0] PRE_8T    = 2'd1;
   localparam logic [1:0] PRE_64T   = 2'd2;
   localparam logic [1:0] PRE_1024T = 2'd3;

   // Timer mode: divided by the prescaler, or one decrement per tick after underflow.
   typedef enum logic {
      MODE_PRESCALED = 1'b0,
      MODE_FREERUN   = 1'b1
   } tim_mode_e;

   // Reload value for the prescale counter: N-1 ticks between decrements.
   function automatic logic [9:0] presc_reload(input logic [1:0] sel);
      logic [9:0] r;
      case (sel)
         PRE_1T:  r = 10'd0;
         PRE_8T:  r = 10'd7;
         PRE_64T: r = 10'd63;
         default: r = 10'd1023;
      endcase
      return r;
   endfunction

   // Pin/latch mix seen when reading a port: output bits show the latch, inputs the pins.
   function automatic logic [7:0] port_mix(input logic [7:0] out_q, input logic [7:0] oe,
                                           input logic [7:0] pins);
      return (out_q & oe) | (pins & ~oe);
   endfunction

endpackage

// File: rtl/riot_timer.sv
// RIOT interval timer: 8-bit count, 10-bit prescale counter, PRESCALED/FREERUN
// mode and the underflow flag. All activity is qualified by i_tick; i_load and
// i_rd_clr arrive already qualified by the bus access.
module riot_timer
   import riot_pia_pkg::*;
#(
   parameter logic [7:0] TIMER_RESET  = 8'hFF,
   parameter logic [1:0] PRESCALE_RST = 2'd3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_tick,
   input  logic       i_load,
   input  logic [7:0] i_val,
   input  logic [1:0] i_sel,
   input  logic       i_rd_clr,
   output logic [7:0] o_value_nxt,
   output logic       o_flag_nxt
);

   logic [7:0] r_value;
   logic [9:0] r_pre;
   logic [1:0] r_sel;
   logic       r_flag;
   tim_mode_e  r_mode;

   logic [7:0] w_value_nxt;
   logic [9:0] w_pre_nxt;
   logic [1:0] w_sel_nxt;
   logic       w_flag_nxt;
   tim_mode_e  w_mode_nxt;
   logic       w_dec;
   logic       w_underflow;

   // Next-state: load has priority over everything; underflow set beats an INTIM clear.
   // A load parks the prescaler at zero so the first decrement lands on the next tick.
   always_comb begin
      w_value_nxt = r_value;
      w_pre_nxt   = r_pre;
      w_sel_nxt   = r_sel;
      w_flag_nxt  = r_flag;
      w_mode_nxt  = r_mode;
      w_dec       = 1'b0;
      w_underflow = 1'b0;
      if (i_tick) begin
         if (i_load) begin
            w_value_nxt = i_val;
            w_sel_nxt   = i_sel;
            w_pre_nxt   = 10'd0;
            w_mode_nxt  = MODE_PRESCALED;
            w_flag_nxt  = 1'b0;
         end else begin
            w_dec = (r_mode == MODE_FREERUN) || (r_pre == 10'd0);
            if (r_mode == MODE_PRESCALED) begin
               w_pre_nxt = (r_pre == 10'd0) ? presc_reload(r_sel) : (r_pre - 10'd1);
            end
            if (w_dec) begin
               w_value_nxt = r_value - 8'd1;
               if (r_value == 8'd0) begin
                  w_underflow = 1'b1;
                  w_flag_nxt  = 1'b1;
                  w_mode_nxt  = MODE_FREERUN;
               end
            end
            if (!w_underflow && i_rd_clr) begin
               w_flag_nxt = 1'b0;
            end
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_value <= TIMER_RESET;
         r_pre   <= presc_reload(PRESCALE_RST);
         r_sel   <= PRESCALE_RST;
         r_flag  <= 1'b0;
         r_mode  <= MODE_PRESCALED;
      end else begin
         r_value <= w_value_nxt;
         r_pre   <= w_pre_nxt;
         r_sel   <= w_sel_nxt;
         r_flag  <= w_flag_nxt;
         r_mode  <= w_mode_nxt;
      end
   end

   // INTIM/TIMINT reads return the count and flag as they stand after this tick.
   assign o_value_nxt = w_value_nxt;
   assign o_flag_nxt  = w_flag_nxt;

endmodule

// File: rtl/riot_pia.sv
// 6532 RIOT bus responder: port A/B latches and direction registers, PA7 edge
// detector, interrupt enables, registered read mux and the interval timer.
// Read data appears on the clock edge after the access and holds until the next read.
module riot_pia
   import riot_pia_pkg::*;
#(
   parameter logic [7:0] TIMER_RESET  = 8'hFF,
   parameter logic [1:0] PRESCALE_RST = 2'd3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_en,
   input  logic       cs,
   input  logic [4:0] addr,
   input  logic       we,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   input  logic [7:0] pa_in,
   output logic [7:0] pa_out,
   output logic [7:0] pa_oe,
   input  logic [7:0] pb_in,
   output logic [7:0] pb_out,
   output logic [7:0] pb_oe,
   output logic       irq
);

   logic [7:0] r_pa_out;
   logic [7:0] r_pa_oe;
   logic [7:0] r_pb_out;
   logic [7:0] r_pb_oe;
   logic [7:0] r_rdata;
   logic       r_irq;
   logic       r_tim_ie;
   logic       r_pa7_ie;
   logic       r_pa7_pol;
   logic       r_pa7_flag;
   logic       r_pa7_d;

   logic       w_acc;
   logic       w_wr;
   logic       w_rd;
   logic       w_wr_port;
   logic       w_wr_edge;
   logic       w_tim_load;
   logic       w_rd_intim;
   logic       w_rd_timint;
   logic       w_pa7_edge;
   logic [7:0] w_tim_value_nxt;
   logic       w_tim_flag_nxt;
   logic       w_tim_ie_nxt;
   logic       w_pa7_flag_nxt;
   logic       w_pa7_ie_nxt;
   logic       w_pa7_pol_nxt;
   logic       w_irq_nxt;
   logic [7:0] w_rd_mux;

   // Access decode; cpu_en gates every side effect.
   assign w_acc       = cs & cpu_en;
   assign w_wr        = w_acc & we;
   assign w_rd        = w_acc & ~we;
   assign w_wr_port   = w_wr & ~addr[4] & ~addr[2];
   assign w_wr_edge   = w_wr & ~addr[4] & addr[2];
   assign w_tim_load  = w_wr & addr[4] & addr[2];
   assign w_rd_intim  = w_rd & addr[2] & ~addr[0];
   assign w_rd_timint = w_rd & addr[2] & addr[0];

   // Selected PA7 transition, compared against last clock's pin sample.
   assign w_pa7_edge  = r_pa7_pol ? (~r_pa7_d & pa_in[7]) : (r_pa7_d & ~pa_in[7]);

   riot_timer #(
      .TIMER_RESET (TIMER_RESET),
      .PRESCALE_RST(PRESCALE_RST)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_tick     (cpu_en),
      .i_load     (w_tim_load),
      .i_val      (wdata),
      .i_sel      (addr[1:0]),
      .i_rd_clr   (w_rd_intim),
      .o_value_nxt(w_tim_value_nxt),
      .o_flag_nxt (w_tim_flag_nxt)
   );

   // Next values for enables and the PA7 flag; an edge wins over a TIMINT clear.
   always_comb begin
      w_tim_ie_nxt   = r_tim_ie;
      w_pa7_ie_nxt   = r_pa7_ie;
      w_pa7_pol_nxt  = r_pa7_pol;
      w_pa7_flag_nxt = r_pa7_flag;
      if (w_tim_load || w_rd_intim) begin
         w_tim_ie_nxt = addr[3];
      end
      if (w_wr_edge) begin
         w_pa7_pol_nxt = addr[0];
         w_pa7_ie_nxt  = addr[1];
      end
      if (w_pa7_edge) begin
         w_pa7_flag_nxt = 1'b1;
      end else if (w_rd_timint) begin
         w_pa7_flag_nxt = 1'b0;
      end
      w_irq_nxt = (w_tim_flag_nxt & w_tim_ie_nxt) | (w_pa7_flag_nxt & w_pa7_ie_nxt);
   end

   // Read mux; A4 and A3 do not affect read selection.
   always_comb begin
      w_rd_mux = 8'h00;
      if (!addr[2]) begin
         case (addr[1:0])
            2'd0:    w_rd_mux = port_mix(r_pa_out, r_pa_oe, pa_in);
            2'd1:    w_rd_mux = r_pa_oe;
            2'd2:    w_rd_mux = port_mix(r_pb_out, r_pb_oe, pb_in);
            default: w_rd_mux = r_pb_oe;
         endcase
      end else if (!addr[0]) begin
         w_rd_mux = w_tim_value_nxt;
      end else begin
         w_rd_mux = {w_tim_flag_nxt, r_pa7_flag, 6'b00_0000};
      end
   end

   // Register file, read data and irq. The PA7 sampler tracks the pin even in
   // reset so that leaving reset never produces a spurious edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pa_out   <= 8'h00;
         r_pa_oe    <= 8'h00;
         r_pb_out   <= 8'h00;
         r_pb_oe    <= 8'h00;
         r_rdata    <= 8'h00;
         r_irq      <= 1'b0;
         r_tim_ie   <= 1'b0;
         r_pa7_ie   <= 1'b0;
         r_pa7_pol  <= 1'b0;
         r_pa7_flag <= 1'b0;
         r_pa7_d    <= pa_in[7];
      end else begin
         if (w_wr_port) begin
            case (addr[1:0])
               2'd0:    r_pa_out <= wdata;
               2'd1:    r_pa_oe  <= wdata;
               2'd2:    r_pb_out <= wdata;
               default: r_pb_oe  <= wdata;
            endcase
         end
         if (w_rd) begin
            r_rdata <= w_rd_mux;
         end
         r_tim_ie   <= w_tim_ie_nxt;
         r_pa7_ie   <= w_pa7_ie_nxt;
         r_pa7_pol  <= w_pa7_pol_nxt;
         r_pa7_flag <= w_pa7_flag_nxt;
         r_pa7_d    <= pa_in[7];
         r_irq      <= w_irq_nxt;
      end
   end

   assign rdata  = r_rdata;
   assign pa_out = r_pa_out;
   assign pa_oe  = r_pa_oe;
   assign pb_out = r_pb_out;
   assign pb_oe  = r_pb_oe;
   assign irq    = r_irq;

endmodule

// File: tb/tb_riot_pia.sv
// Directed bench for riot_pia. Inputs change on the falling edge, outputs are
// sampled on the falling edge; every bus task occupies exactly one clock.
module tb_riot_pia;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cpu_en;
   logic       cs;
   logic [4:0] addr;
   logic       we;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic [7:0] pa_in;
   logic [7:0] pa_out;
   logic [7:0] pa_oe;
   logic [7:0] pb_in;
   logic [7:0] pb_out;
   logic [7:0] pb_oe;
   logic       irq;

   int checks   = 0;
   int failures = 0;

   // Clock
   always #5 clk = ~clk;

   riot_pia dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cpu_en(cpu_en),
      .cs    (cs),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .pa_in (pa_in),
      .pa_out(pa_out),
      .pa_oe (pa_oe),
      .pb_in (pb_in),
      .pb_out(pb_out),
      .pb_oe (pb_oe),
      .irq   (irq)
   );

   // Driver tasks
   task automatic do_write(input logic [4:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk); @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic do_read(input logic [4:0] a, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; addr = a;
      @(posedge clk); @(negedge clk);
      d = rdata;
      cs = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst_n = 1'b0; cpu_en = 1'b1; cs = 1'b0; we = 1'b0; addr = 5'h00; wdata = 8'h00;
      pa_in = 8'h00; pb_in = 8'h00;
      @(negedge clk);
      idle(3);
      rst_n = 1'b1;
      checks++; if ({pa_out, pa_oe, pb_out, pb_oe} !== 32'h0) begin failures++;
         $display("FAIL reset_ports got %h expected 00000000", {pa_out, pa_oe, pb_out, pb_oe}); end
      checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got %h expected 00", rdata); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b expected 0", irq); end
      do_read(5'h00, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_swcha got %h expected 00", v); end
      do_read(5'h01, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_swacnt got %h expected 00", v); end
      do_read(5'h04, v);
      checks++; if (v !== 8'hFF) begin failures++; $display("FAIL reset_intim got %h expected FF", v); end
   endtask

   task automatic test_ports();
      logic [7:0] v;
      do_write(5'h01, 8'hF0);
      do_write(5'h00, 8'hA5);
      pa_in = 8'h3C;
      checks++; if (pa_out !== 8'hA5) begin failures++; $display("FAIL pa_out got %h expected A5", pa_out); end
      checks++; if (pa_oe !== 8'hF0) begin failures++; $display("FAIL pa_oe got %h expected F0", pa_oe); end
      do_read(5'h00, v);
      checks++; if (v !== 8'hAC) begin failures++; $display("FAIL swcha_mix got %h expected AC", v); end
      do_write(5'h03, 8'h0F);
      checks++; if (rdata !== 8'hAC) begin failures++; $display("FAIL rdata_hold got %h expected AC", rdata); end
      do_write(5'h02, 8'h5A);
      pb_in = 8'hC3;
      do_read(5'h02, v);
      checks++; if (v !== 8'hCA) begin failures++; $display("FAIL swchb_mix got %h expected CA", v); end
      // A4=1,A2=0 writes land nowhere
      do_write(5'h10, 8'hFF);
      do_write(5'h13, 8'hFF);
      checks++; if ({pa_out, pa_oe, pb_out, pb_oe} !== 32'hA5F05A0F) begin failures++;
         $display("FAIL dead_write got %h expected A5F05A0F", {pa_out, pa_oe, pb_out, pb_oe}); end
      do_read(5'h03, v);
      checks++; if (v !== 8'h0F) begin failures++; $display("FAIL swbcnt got %h expected 0F", v); end
   endtask

   task automatic test_timer_64t();
      logic [7:0] v;
      logic [7:0] exp_v;
      do_write(5'h16, 8'h03);                  // tick T
      for (int k = 1; k <= 193; k++) begin     // tick T+k
         do_read(5'h04, v);
         if (k == 1 || k == 64 || k == 65 || k == 128 || k == 129 || k == 192 || k == 193) begin
            exp_v = (k <= 64) ? 8'h02 : (k <= 128) ? 8'h01 : (k <= 192) ? 8'h00 : 8'hFF;
            checks++; if (v !== exp_v) begin failures++;
               $display("FAIL intim_64t_k%0d got %h expected %h", k, v, exp_v); end
         end
      end
      do_read(5'h05, v);                       // T+194: flag survived same-tick INTIM read
      checks++; if (v !== 8'h80) begin failures++; $display("FAIL timint_underflow got %h expected 80", v); end
      do_write(5'h14, 8'h10);                  // T+195: reload in FREERUN, 1T
      do_read(5'h05, v);                       // T+196
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL timint_after_load got %h expected 00", v); end
      do_read(5'h04, v);                       // T+197
      checks++; if (v !== 8'h0E) begin failures++; $display("FAIL intim_1t_reload got %h expected 0E", v); end
   endtask

   task automatic test_underflow_1t();
      logic [7:0] v;
      do_write(5'h14, 8'h02);                  // L
      idle(2);                                 // L+1 01, L+2 00
      do_read(5'h04, v);                       // L+3 underflow
      checks++; if (v !== 8'hFF) begin failures++; $display("FAIL intim_1t_uf got %h expected FF", v); end
      do_read(5'h05, v);                       // L+4
      checks++; if (v !== 8'h80) begin failures++; $display("FAIL timint_same_tick got %h expected 80", v); end
      do_read(5'h04, v);                       // L+5 clears flag
      checks++; if (v !== 8'hFD) begin failures++; $display("FAIL intim_freerun got %h expected FD", v); end
      do_read(5'h05, v);                       // L+6
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL timint_cleared got %h expected 00", v); end
   endtask

   task automatic test_load_vs_underflow();
      logic [7:0] v;
      do_write(5'h14, 8'h02);                  // M
      idle(2);
      do_write(5'h14, 8'h05);                  // M+3 collides with underflow
      do_read(5'h05, v);                       // M+4
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL load_wins_flag got %h expected 00", v); end
      do_read(5'h04, v);                       // M+5
      checks++; if (v !== 8'h03) begin failures++; $display("FAIL load_wins_value got %h expected 03", v); end
   endtask

   task automatic test_timer_irq();
      logic [7:0] v;
      do_write(5'h1C, 8'h01);                  // 1T, ie=1
      idle(2);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL tim_irq_set got %b expected 1", irq); end
      do_read(5'h0C, v);                       // INTIM with A3=1 clears flag
      checks++; if (v !== 8'hFE) begin failures++; $display("FAIL tim_irq_intim got %h expected FE", v); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL tim_irq_clr got %b expected 0", irq); end
      do_write(5'h17, 8'hFF);                  // park timer far from underflow, ie=0
   endtask

   task automatic test_pa7();
      logic [7:0] v;
      do_write(5'h07, 8'h00);                  // rising edge, ie=1
      pa_in = 8'hBC;
      idle(2);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pa7_irq got %b expected 1", irq); end
      do_read(5'h05, v);
      checks++; if (v !== 8'h40) begin failures++; $display("FAIL pa7_timint got %h expected 40", v); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL pa7_irq_clr got %b expected 0", irq); end
      do_read(5'h05, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL pa7_timint2 got %h expected 00", v); end
      pa_in = 8'h3C;                           // falling edge is not selected
      idle(2);
      do_read(5'h05, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL pa7_fall_ignored got %h expected 00", v); end
   endtask

   task automatic test_cpu_en();
      logic [7:0] v;
      do_write(5'h16, 8'h50);
      do_read(5'h04, v);
      checks++; if (v !== 8'h4F) begin failures++; $display("FAIL cpuen_pre got %h expected 4F", v); end
      cpu_en = 1'b0;
      cs = 1'b1; we = 1'b1; addr = 5'h00; wdata = 8'h11;
      idle(100);
      cs = 1'b0; we = 1'b0;
      checks++; if (rdata !== 8'h4F) begin failures++; $display("FAIL cpuen_rdata got %h expected 4F", rdata); end
      checks++; if (pa_out !== 8'hA5) begin failures++; $display("FAIL cpuen_write got %h expected A5", pa_out); end
      cpu_en = 1'b1;
      do_read(5'h04, v);
      checks++; if (v !== 8'h4F) begin failures++; $display("FAIL cpuen_frozen got %h expected 4F", v); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      pa_in = 8'hBC;                           // rising edge with pa7 ie=1 still armed
      idle(2);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL premid_irq got %b expected 1", irq); end
      cpu_en = 1'b0;
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      cpu_en = 1'b1;
      checks++; if ({pa_out, pa_oe, pb_out, pb_oe} !== 32'h0) begin failures++;
         $display("FAIL mid_reset_ports got %h expected 00000000", {pa_out, pa_oe, pb_out, pb_oe}); end
      checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL mid_reset_rdata got %h expected 00", rdata); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_reset_irq got %b expected 0", irq); end
      do_read(5'h04, v);
      checks++; if (v !== 8'hFF) begin failures++; $display("FAIL mid_reset_intim got %h expected FF", v); end
      do_read(5'h05, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_reset_timint got %h expected 00", v); end
   endtask

   initial begin
      test_reset();
      test_ports();
      test_timer_64t();
      test_underflow_1t();
      test_load_vs_underflow();
      test_timer_irq();
      test_pa7();
      test_cpu_en();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
